audio_mixer: RTL and testbench

- Parametrised multi-channel audio sample conditioner. Generalises the single-ADC capture/filter path that feeds the HDMI audio encoder to N channels.
- Per-channel gain, per-channel L/R routing, stereo accumulate, saturation, optional output low-pass filter.
- Time-multiplexed: one multiply per clock. Runs on the pixel clock; its out_l/out_r feed audio_sample_word of the HDMI block.

---
 rtl/audio_mixer.sv | 137 +++++++++++++
 tb/tb_audio_mixer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer.sv
// audio_mixer: N-channel gain/route/saturate mixer, one multiply per clock; optional LPF via AUDIO_MIXER_LPF_EN
module audio_mixer #(
    parameter int CHANNELS   = 2,
    parameter int IN_WIDTH   = 12,
    parameter int OUT_WIDTH  = 16,
    parameter int GAIN_WIDTH = 8,
    parameter int LPF_SHIFT  = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           sample_tick,
    input  logic [CHANNELS-1:0]            in_valid,
    input  logic [CHANNELS*IN_WIDTH-1:0]   in_data,
    input  logic [CHANNELS*GAIN_WIDTH-1:0] gain,
    input  logic [CHANNELS-1:0]            route_l,
    input  logic [CHANNELS-1:0]            route_r,
    input  logic                           clear_flags,
    output logic [OUT_WIDTH-1:0]           out_l,
    output logic [OUT_WIDTH-1:0]           out_r,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           clip_l,
    output logic                           clip_r,
    output logic                           overrun
);
    localparam int PW = IN_WIDTH + GAIN_WIDTH + 1;
    localparam int AW = PW + $clog2(CHANNELS);
    localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int VW = AW + OUT_WIDTH - IN_WIDTH;
    localparam logic signed [VW-1:0] VMAX = VW'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [VW-1:0] VMIN = -VMAX - 1;
    typedef enum logic [2:0] {IDLE, MIX, SAT, FILT, OUT} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] idx;
    logic last;
    logic signed [IN_WIDTH-1:0] hold [CHANNELS];
    logic signed [AW-1:0] acc_l, acc_r;
    logic signed [PW-1:0] p;
    logic signed [OUT_WIDTH-1:0] sat_l, sat_r;
    logic [OUT_WIDTH:0] sat_l_w, sat_r_w;
    // returns {clipped, clamped value}
    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [AW-1:0] a);
        logic signed [VW-1:0] s;
        s = (VW'(a) >>> (GAIN_WIDTH-1)) <<< (OUT_WIDTH-IN_WIDTH);
        return s > VMAX ? {1'b1, VMAX[OUT_WIDTH-1:0]} :
               s < VMIN ? {1'b1, VMIN[OUT_WIDTH-1:0]} : {1'b0, s[OUT_WIDTH-1:0]};
    endfunction
`ifdef AUDIO_MIXER_LPF_EN
    localparam int YW = OUT_WIDTH + LPF_SHIFT;
    logic signed [YW-1:0] y_l, y_r;
    function automatic logic signed [YW-1:0] lpf(input logic signed [YW-1:0] y,
                                                 input logic signed [OUT_WIDTH-1:0] v);
        logic signed [YW:0] d;
        d = ((YW+1)'(v) <<< LPF_SHIFT) - (YW+1)'(y);
        return y + YW'(d >>> LPF_SHIFT);
    endfunction
`endif
    assign busy = state != IDLE;
    assign last = idx == IW'(CHANNELS-1);
    assign sat_l_w = saturate(acc_l);
    assign sat_r_w = saturate(acc_r);
    assign p = PW'(hold[idx]) * PW'($signed({1'b0, gain[32'(idx)*GAIN_WIDTH +: GAIN_WIDTH]}));
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = sample_tick ? MIX : IDLE;
            MIX:  state_nxt = last ? SAT : MIX;
`ifdef AUDIO_MIXER_LPF_EN
            SAT:  state_nxt = FILT;
`else
            SAT:  state_nxt = OUT;
`endif
            FILT: state_nxt = OUT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            sat_l     <= '0;
            sat_r     <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            clip_l    <= 1'b0;
            clip_r    <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) hold[i] <= '0;
`ifdef AUDIO_MIXER_LPF_EN
            y_l <= '0;
            y_r <= '0;
`endif
        end else begin
            state     <= state_nxt;
            out_valid <= state == OUT;
            for (int i = 0; i < CHANNELS; i++)
                if (in_valid[i])
                    hold[i] <= {~in_data[i*IN_WIDTH+IN_WIDTH-1], in_data[i*IN_WIDTH +: IN_WIDTH-1]};
            // a set in the same cycle as a clear wins
            clip_l  <= (state == SAT && sat_l_w[OUT_WIDTH]) || (clip_l && !clear_flags);
            clip_r  <= (state == SAT && sat_r_w[OUT_WIDTH]) || (clip_r && !clear_flags);
            overrun <= (sample_tick && busy) || (overrun && !clear_flags);
            if (state == IDLE) begin
                acc_l <= '0;
                acc_r <= '0;
                idx   <= '0;
            end
            if (state == MIX) begin
                acc_l <= route_l[idx] ? acc_l + AW'(p) : acc_l;
                acc_r <= route_r[idx] ? acc_r + AW'(p) : acc_r;
                idx   <= idx + 1'b1;
            end
            if (state == SAT) begin
                sat_l <= sat_l_w[OUT_WIDTH-1:0];
                sat_r <= sat_r_w[OUT_WIDTH-1:0];
            end
`ifdef AUDIO_MIXER_LPF_EN
            if (state == FILT) begin
                y_l <= lpf(y_l, sat_l);
                y_r <= lpf(y_r, sat_r);
            end
            if (state == OUT) begin
                out_l <= OUT_WIDTH'(y_l >>> LPF_SHIFT);
                out_r <= OUT_WIDTH'(y_r >>> LPF_SHIFT);
            end
`else
            if (state == OUT) begin
                out_l <= sat_l;
                out_r <= sat_r;
            end
`endif
        end
    end
endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: directed-vector bench for audio_mixer (default build and AUDIO_MIXER_LPF_EN build)
module tb_audio_mixer;
    logic clk = 0, reset_n = 0, sample_tick = 0, clear_flags = 0;
    logic [1:0] in_valid = 0, route_l = 0, route_r = 0;
    logic [23:0] in_data = 0;
    logic [15:0] gain = 0;
    logic signed [15:0] out_l, out_r;
    logic out_valid, busy, clip_l, clip_r, overrun;
    int vectors = 0, miscompares = 0;
    int lat, pulses;
    logic busy1;
`ifdef AUDIO_MIXER_LPF_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    audio_mixer dut (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .in_valid(in_valid),
        .in_data(in_data), .gain(gain), .route_l(route_l), .route_r(route_r),
        .clear_flags(clear_flags), .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
        .busy(busy), .clip_l(clip_l), .clip_r(clip_r), .overrun(overrun)
    );
    always #5 clk = ~clk;
    task automatic load(input logic [11:0] a, input logic [11:0] b);
        in_data = {b, a};
        in_valid = 2'b11;
        @(posedge clk); #1;
        in_valid = 2'b00;
    endtask
    // tick at edge 0; optional second tick / clear at edge k; records first out_valid edge
    task automatic run_seq(input int tick2, input int clr);
        lat = -1;
        pulses = 0;
        sample_tick = 1;
        @(posedge clk); #1;
        sample_tick = 0;
        for (int k = 1; k <= 10; k++) begin
            sample_tick = (k == tick2);
            clear_flags = (k == clr);
            @(posedge clk); #1;
            if (k == 1) busy1 = busy;
            if (out_valid) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        sample_tick = 0;
        clear_flags = 0;
    endtask
    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1;
        vectors++;
        if ({out_l, out_r} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_out got l=%0d r=%0d want 0 0", out_l, out_r);
        end
        vectors++;
        if ({out_valid, busy, clip_l, clip_r, overrun} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 00000", {out_valid, busy, clip_l, clip_r, overrun});
        end
        gain = {8'd255, 8'd255};
        route_l = 2'b11;
        route_r = 2'b11;
        run_seq(0, 0);
        vectors++;
        if (lat !== LAT || pulses !== 1) begin
            miscompares++;
            $display("FAIL reset_tick_latency got lat=%0d pulses=%0d want %0d 1", lat, pulses, LAT);
        end
        vectors++;
        if (out_l !== 16'sd0 || out_r !== 16'sd0) begin
            miscompares++;
            $display("FAIL reset_tick_out got l=%0d r=%0d want 0 0", out_l, out_r);
        end
    endtask
    task automatic test_unity();
        load(12'hC00, 12'h800);
        gain = {8'd128, 8'd128};
        route_l = 2'b01;
        route_r = 2'b00;
        run_seq(0, 0);
        vectors++;
        if (lat !== 4 || pulses !== 1 || busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL unity_timing got lat=%0d pulses=%0d busy=%b want 4 1 1", lat, pulses, busy1);
        end
        vectors++;
        if (out_l !== 16'sd16384 || out_r !== 16'sd0) begin
            miscompares++;
            $display("FAIL unity_out got l=%0d r=%0d want 16384 0", out_l, out_r);
        end
        vectors++;
        if (clip_l !== 1'b0 || clip_r !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL unity_flags got clip=%b%b busy=%b want 00 0", clip_l, clip_r, busy);
        end
    endtask
    task automatic test_mix();
        load(12'hC00, 12'h600);
        gain = {8'd64, 8'd128};
        route_l = 2'b11;
        route_r = 2'b10;
        run_seq(0, 0);
        vectors++;
        if (out_l !== 16'sd12288 || out_r !== -16'sd4096) begin
            miscompares++;
            $display("FAIL mix_route_gain got l=%0d r=%0d want 12288 -4096", out_l, out_r);
        end
        load(12'h800, 12'h7FF);
        gain = {8'd1, 8'd128};
        route_l = 2'b00;
        route_r = 2'b10;
        run_seq(0, 0);
        vectors++;
        if (out_l !== 16'sd0 || out_r !== -16'sd16) begin
            miscompares++;
            $display("FAIL mix_floor got l=%0d r=%0d want 0 -16", out_l, out_r);
        end
    endtask
    task automatic test_saturation();
        load(12'hFFF, 12'hFFF);
        gain = {8'd255, 8'd255};
        route_l = 2'b11;
        route_r = 2'b00;
        run_seq(0, 0);
        vectors++;
        if (out_l !== 16'sd32767 || clip_l !== 1'b1 || clip_r !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_pos got l=%0d clip=%b%b want 32767 10", out_l, clip_l, clip_r);
        end
        clear_flags = 1;
        @(posedge clk); #1;
        clear_flags = 0;
        load(12'h000, 12'h000);
        route_l = 2'b00;
        route_r = 2'b11;
        run_seq(0, 0);
        vectors++;
        if (out_r !== -16'sd32768 || clip_r !== 1'b1 || clip_l !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_neg got r=%0d clip=%b%b want -32768 01", out_r, clip_l, clip_r);
        end
    endtask
    task automatic test_overrun();
        clear_flags = 1;
        @(posedge clk); #1;
        clear_flags = 0;
        load(12'hC00, 12'h800);
        gain = {8'd128, 8'd128};
        route_l = 2'b01;
        route_r = 2'b00;
        run_seq(2, 0);
        vectors++;
        if (lat !== 4 || pulses !== 1) begin
            miscompares++;
            $display("FAIL overrun_pulses got lat=%0d pulses=%0d want 4 1", lat, pulses);
        end
        vectors++;
        if (overrun !== 1'b1 || out_l !== 16'sd16384) begin
            miscompares++;
            $display("FAIL overrun_flag got ovr=%b l=%0d want 1 16384", overrun, out_l);
        end
    endtask
    task automatic test_clear_collision();
        load(12'hFFF, 12'hFFF);
        gain = {8'd255, 8'd255};
        route_l = 2'b11;
        route_r = 2'b00;
        run_seq(0, 0);
        run_seq(0, 3);
        vectors++;
        if (clip_l !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_vs_set got clip_l=%b ovr=%b want 1 0", clip_l, overrun);
        end
        clear_flags = 1;
        @(posedge clk); #1;
        clear_flags = 0;
        vectors++;
        if ({clip_l, clip_r, overrun} !== 3'b000) begin
            miscompares++;
            $display("FAIL clear_alone got %b want 000", {clip_l, clip_r, overrun});
        end
    endtask
    task automatic test_reset_abort();
        sample_tick = 1;
        @(posedge clk); #1;
        sample_tick = 0;
        @(posedge clk); #1;
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        vectors++;
        if (pulses !== 0 || busy !== 1'b0 || out_l !== 16'sd0) begin
            miscompares++;
            $display("FAIL reset_abort got pulses=%0d busy=%b l=%0d want 0 0 0", pulses, busy, out_l);
        end
    endtask
`ifdef AUDIO_MIXER_LPF_EN
    task automatic test_lpf();
        int want [3];
        want = '{2048, 3840, 5408};
        load(12'hC00, 12'h800);
        gain = {8'd128, 8'd128};
        route_l = 2'b01;
        route_r = 2'b00;
        for (int n = 0; n < 3; n++) begin
            run_seq(0, 0);
            vectors++;
            if (lat !== 5 || int'(out_l) !== want[n]) begin
                miscompares++;
                $display("FAIL lpf_step%0d got lat=%0d l=%0d want 5 %0d", n, lat, out_l, want[n]);
            end
        end
    endtask
`endif
    initial begin
        test_reset();
`ifdef AUDIO_MIXER_LPF_EN
        test_lpf();
`else
        test_unity();
        test_mix();
        test_saturation();
        test_overrun();
        test_clear_collision();
`endif
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
